// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline control core.
// Forward-select encoding, stage indices and default widths.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int XLEN_DEF    = 64;
    localparam int RADDR_W_DEF = 5;

    function automatic fwd_sel_e fwd_pick(input logic mem_hit,
                                          input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/rv_hazard_detect.sv
// ID-stage hazard detector; RV_FWD_EN selects load-use-only stalls,
// otherwise any RegWrite producer in EX or MEM stalls the consumer.
module rv_hazard_detect
    import rv_pipe_pkg::*;
#(
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               i_v_id,
    input  logic [RADDR_W-1:0] i_id_rs1,
    input  logic [RADDR_W-1:0] i_id_rs2,
    input  logic               i_id_use_rs1,
    input  logic               i_id_use_rs2,
    input  logic               i_v_ex,
    input  logic [RADDR_W-1:0] i_ex_rd,
    input  logic               i_ex_regwrite,
    input  logic               i_ex_memread,
    input  logic               i_v_mem,
    input  logic [RADDR_W-1:0] i_mem_rd,
    input  logic               i_mem_regwrite,
    output logic               o_hazard
);

`ifdef RV_FWD_EN
    localparam logic STALL_ALL = 1'b0;
`else
    localparam logic STALL_ALL = 1'b1;
`endif

    logic w_ex_q;
    logic w_mem_q;
    logic w_ex_hit;
    logic w_mem_hit;

    // Without forwarding every producer stalls; with it only loads in EX do.
    assign w_ex_q  = i_v_ex & i_ex_regwrite & (i_ex_memread | STALL_ALL);
    assign w_mem_q = i_v_mem & i_mem_regwrite & STALL_ALL;

    assign w_ex_hit = w_ex_q & (i_ex_rd != '0) &
                      ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

    assign w_mem_hit = w_mem_q & (i_mem_rd != '0) &
                       ((i_id_use_rs1 & (i_id_rs1 == i_mem_rd)) |
                        (i_id_use_rs2 & (i_id_rs2 == i_mem_rd)));

    assign o_hazard = i_v_id & (w_ex_hit | w_mem_hit);

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Control core for the IF/ID/EX/MEM/WB pipeline: PC, valids, stall/flush.
// Define RV_FWD_EN to enable EX operand forwarding (load-use-only stalls).
module rv_pipe_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              RADDR_W  = RADDR_W_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               ex_br_taken,
    input  logic [XLEN-1:0]    ex_br_target,
    output logic [XLEN-1:0]    pc,
    output logic               if_id_we,
    output logic               v_id,
    output logic               v_ex,
    output logic               v_mem,
    output logic               v_wb,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               wb_we,
    output logic               stall,
    output logic               flush
);

    logic [XLEN-1:0]      r_pc;
    logic [STG_WB:STG_ID] r_v;
    logic [RADDR_W-1:0]   r_ex_rd;
    logic [RADDR_W-1:0]   r_mem_rd;
    logic                 r_ex_regwrite;
    logic                 r_ex_memread;
    logic                 r_mem_regwrite;
    logic                 r_wb_regwrite;
    logic                 w_hazard;
    logic                 w_flush;
    logic                 w_stall;

    rv_hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard (
        .i_v_id         (r_v[STG_ID]),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_use_rs1   (id_use_rs1),
        .i_id_use_rs2   (id_use_rs2),
        .i_v_ex         (r_v[STG_EX]),
        .i_ex_rd        (r_ex_rd),
        .i_ex_regwrite  (r_ex_regwrite),
        .i_ex_memread   (r_ex_memread),
        .i_v_mem        (r_v[STG_MEM]),
        .i_mem_rd       (r_mem_rd),
        .i_mem_regwrite (r_mem_regwrite),
        .o_hazard       (w_hazard)
    );

    // A redirect kills the stalled ID instruction, so it overrides the stall.
    assign w_flush = ~reset & r_v[STG_EX] & ex_br_taken;
    assign w_stall = ~reset & w_hazard & ~w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_v            <= '0;
            r_ex_rd        <= '0;
            r_mem_rd       <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_wb_regwrite  <= 1'b0;
        end else begin
            r_v[STG_WB]    <= r_v[STG_MEM];
            r_v[STG_MEM]   <= r_v[STG_EX];
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_wb_regwrite  <= r_mem_regwrite;
            r_ex_rd        <= id_rd;
            r_ex_regwrite  <= id_regwrite;
            r_ex_memread   <= id_memread;
            if (w_flush) begin
                r_pc        <= ex_br_target;
                r_v[STG_ID] <= 1'b0;
                r_v[STG_EX] <= 1'b0;
            end else if (w_stall) begin
                r_v[STG_EX] <= 1'b0;
            end else begin
                r_v[STG_EX] <= r_v[STG_ID];
                r_v[STG_ID] <= if_valid;
                if (if_valid)
                    r_pc <= r_pc + XLEN'(PC_STEP);
            end
        end
    end

`ifdef RV_FWD_EN
    fwd_sel_e r_fwd_a;
    fwd_sel_e r_fwd_b;
    logic     w_ex_src;
    logic     w_mem_src;

    // Selects are resolved as the instruction enters EX: the current EX
    // producer will sit in MEM and the current MEM producer in WB.
    assign w_ex_src  = r_v[STG_EX] & r_ex_regwrite & (r_ex_rd != '0);
    assign w_mem_src = r_v[STG_MEM] & r_mem_regwrite & (r_mem_rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_flush | w_stall | ~r_v[STG_ID]) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= fwd_pick(w_ex_src & (r_ex_rd == id_rs1),
                                w_mem_src & (r_mem_rd == id_rs1));
            r_fwd_b <= fwd_pick(w_ex_src & (r_ex_rd == id_rs2),
                                w_mem_src & (r_mem_rd == id_rs2));
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    assign pc       = r_pc;
    assign if_id_we = ~w_stall;
    assign v_id     = r_v[STG_ID];
    assign v_ex     = r_v[STG_EX];
    assign v_mem    = r_v[STG_MEM];
    assign v_wb     = r_v[STG_WB];
    assign wb_we    = r_v[STG_WB] & r_wb_regwrite;
    assign stall    = w_stall;
    assign flush    = w_flush;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed bench for rv_pipe_ctrl; expectations follow RV_FWD_EN.
module tb_rv_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        ex_br_taken;
    logic [63:0] ex_br_target;
    logic [63:0] pc;
    logic        if_id_we;
    logic        v_id;
    logic        v_ex;
    logic        v_mem;
    logic        v_wb;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        wb_we;
    logic        stall;
    logic        flush;

    int checks = 0;
    int errors = 0;

`ifdef RV_FWD_EN
    localparam int         LU_STALLS  = 1;
    localparam int         ALU_STALLS = 0;
    localparam logic [1:0] LU_FWD_A   = 2'b10;
    localparam logic [1:0] ALU_FWD    = 2'b01;
`else
    localparam int         LU_STALLS  = 2;
    localparam int         ALU_STALLS = 2;
    localparam logic [1:0] LU_FWD_A   = 2'b00;
    localparam logic [1:0] ALU_FWD    = 2'b00;
`endif

    rv_pipe_ctrl #(
        .XLEN     (64),
        .RADDR_W  (5),
        .RESET_PC (64'h1000),
        .PC_STEP  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .ex_br_taken  (ex_br_taken),
        .ex_br_target (ex_br_target),
        .pc           (pc),
        .if_id_we     (if_id_we),
        .v_id         (v_id),
        .v_ex         (v_ex),
        .v_mem        (v_mem),
        .v_wb         (v_wb),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .wb_we        (wb_we),
        .stall        (stall),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2,
                          input logic [4:0] rd, input logic rw,
                          input logic mr);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic do_reset;
        reset        = 1'b1;
        if_valid     = 1'b0;
        ex_br_taken  = 1'b0;
        ex_br_target = '0;
        id_set(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (pc !== 64'h1000) begin
            errors++;
            $display("FAIL reset_pc got %h want %h", pc, 64'h1000);
        end
        checks++;
        if ({v_id, v_ex, v_mem, v_wb} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids got %b want 0000",
                     {v_id, v_ex, v_mem, v_wb});
        end
        checks++;
        if ({fwd_a_sel, fwd_b_sel, wb_we, stall, flush} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {fwd_a_sel, fwd_b_sel, wb_we, stall, flush});
        end
        if_valid = 1'b1;
        tick;
        tick;
        tick;
        checks++;
        if (pc !== 64'h100C) begin
            errors++;
            $display("FAIL fetch3_pc got %h want %h", pc, 64'h100C);
        end
        checks++;
        if ({v_id, v_ex, v_mem, v_wb} !== 4'b1110) begin
            errors++;
            $display("FAIL fetch3_valids got %b want 1110",
                     {v_id, v_ex, v_mem, v_wb});
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (pc !== 64'h1000 || {v_id, v_ex, v_mem, v_wb} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset got pc=%h v=%b want pc=1000 v=0000",
                     pc, {v_id, v_ex, v_mem, v_wb});
        end
    endtask

    task automatic test_load_use;
        logic [63:0] p0;
        int n;
        do_reset;
        if_valid = 1'b1;
        tick;
        id_set(0, 0, 0, 0, 5, 1, 1);
        tick;
        id_set(5, 7, 1, 1, 6, 1, 0);
        #1;
        p0 = pc;
        checks++;
        if (stall !== 1'b1 || if_id_we !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall got stall=%b we=%b want 1 0",
                     stall, if_id_we);
        end
        n = 0;
        while (stall && n < 5) begin
            tick;
            n++;
        end
        checks++;
        if (n !== LU_STALLS) begin
            errors++;
            $display("FAIL lu_count got %0d want %0d", n, LU_STALLS);
        end
        checks++;
        if (pc !== p0 || v_ex !== 1'b0) begin
            errors++;
            $display("FAIL lu_hold got pc=%h v_ex=%b want pc=%h v_ex=0",
                     pc, v_ex, p0);
        end
        tick;
        id_set(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (v_ex !== 1'b1 || fwd_a_sel !== LU_FWD_A ||
            fwd_b_sel !== 2'b00) begin
            errors++;
            $display("FAIL lu_fwd got v_ex=%b a=%b b=%b want 1 %b 00",
                     v_ex, fwd_a_sel, fwd_b_sel, LU_FWD_A);
        end
    endtask

    task automatic test_alu_chain;
        int n;
        do_reset;
        if_valid = 1'b1;
        tick;
        id_set(0, 0, 0, 0, 5, 1, 0);
        tick;
        id_set(5, 5, 1, 1, 6, 1, 0);
        #1;
        n = 0;
        while (stall && n < 5) begin
            tick;
            n++;
        end
        checks++;
        if (n !== ALU_STALLS) begin
            errors++;
            $display("FAIL alu_count got %0d want %0d", n, ALU_STALLS);
        end
        tick;
        checks++;
        if (fwd_a_sel !== ALU_FWD || fwd_b_sel !== ALU_FWD) begin
            errors++;
            $display("FAIL alu_fwd got a=%b b=%b want %b", fwd_a_sel,
                     fwd_b_sel, ALU_FWD);
        end
        id_set(0, 0, 0, 0, 0, 1, 0);
        tick;
        id_set(0, 0, 1, 1, 6, 1, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall got %b want 0", stall);
        end
        tick;
        id_set(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (v_ex !== 1'b1 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++;
            $display("FAIL x0_fwd got v_ex=%b a=%b b=%b want 1 00 00",
                     v_ex, fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_branch;
        do_reset;
        if_valid = 1'b1;
        tick;
        id_set(0, 0, 0, 0, 5, 1, 1);
        tick;
        id_set(5, 0, 1, 0, 6, 1, 0);
        ex_br_taken  = 1'b1;
        ex_br_target = 64'h2000;
        #1;
        checks++;
        if (flush !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL br_ctrl got flush=%b stall=%b want 1 0",
                     flush, stall);
        end
        tick;
        ex_br_taken = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (pc !== 64'h2000 || v_id !== 1'b0 || v_ex !== 1'b0 ||
            flush !== 1'b0) begin
            errors++;
            $display("FAIL br_redirect got pc=%h id=%b ex=%b fl=%b want 2000 0 0 0",
                     pc, v_id, v_ex, flush);
        end
        tick;
        checks++;
        if (pc !== 64'h2004 || v_id !== 1'b1 || v_ex !== 1'b0) begin
            errors++;
            $display("FAIL br_refetch got pc=%h id=%b ex=%b want 2004 1 0",
                     pc, v_id, v_ex);
        end
    endtask

    task automatic test_fetch_miss;
        logic [63:0] p0;
        do_reset;
        id_set(0, 0, 0, 0, 3, 1, 0);
        if_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        checks++;
        if (wb_we !== 1'b1 || v_wb !== 1'b1) begin
            errors++;
            $display("FAIL miss_full got wb_we=%b v_wb=%b want 1 1",
                     wb_we, v_wb);
        end
        p0 = pc;
        if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (pc !== p0 || v_id !== 1'b0) begin
                errors++;
                $display("FAIL miss_hold%0d got pc=%h v_id=%b want %h 0",
                         i, pc, v_id, p0);
            end
        end
        if_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (v_wb !== 1'b0 || wb_we !== 1'b0) begin
                errors++;
                $display("FAIL miss_wb%0d got v_wb=%b wb_we=%b want 0 0",
                         i, v_wb, wb_we);
            end
        end
        tick;
        checks++;
        if (wb_we !== 1'b1) begin
            errors++;
            $display("FAIL miss_resume got wb_we=%b want 1", wb_we);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        if_valid = 1'b1;
        tick;
        tick;
        ex_br_taken  = 1'b1;
        ex_br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick;
        ex_br_taken = 1'b0;
        checks++;
        if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target got %h want FFFFFFFFFFFFFFFC", pc);
        end
        tick;
        checks++;
        if (pc !== 64'h0) begin
            errors++;
            $display("FAIL wrap_pc got %h want 0", pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_load_use;
        test_alu_chain;
        test_branch;
        test_fetch_miss;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
